// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - I2C target endpoint: START/STOP detect, address match, byte handshake
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   clr      synchronous active-high reset
//   scl_in   raw SCL from pad (asynchronous, input only)
//   sda_in   raw SDA from pad (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release
//   rx_data  last received write byte
//   rx_valid one-cycle pulse, rx_data is new this cycle
//   tx_req   one-cycle pulse, next read byte requested
//   tx_data  read byte, valid the cycle after tx_req
//   busy     set on an address match, cleared by STOP or START
module i2c_slave_if #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  // Input synchronisers and history flops. Reset to 1 (idle bus level) so a
  // reset never manufactures a START edge on its own.
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must have been high on both samples so that SCL and SDA moving in
  // the same sample window is not taken as a bus condition.
  assign w_start    = ~w_sda & r_sda_d & w_scl & r_scl_d;
  assign w_stop     = w_sda & ~r_sda_d & w_scl & r_scl_d;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic        r_ack_half;   // first SCL fall of an ACK slot already seen
  logic        r_sda_oe;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_tx_req;
  logic        r_tx_load;    // tx_data is captured one cycle after tx_req
  logic        r_busy;
  logic [7:0]  r_tx_sr;

  state_t      w_state_nx;
  logic [2:0]  w_cnt_nx;
  logic [7:0]  w_shift_nx;
  logic        w_rw_nx;
  logic        w_ack_half_nx;
  logic        w_oe_nx;
  logic [7:0]  w_rx_data_nx;
  logic        w_rx_valid_nx;
  logic        w_tx_req_nx;
  logic        w_busy_nx;
  logic [7:0]  w_tx_sr_nx;
  logic [7:0]  w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_ack_half <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_tx_load  <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_sr    <= 8'h00;
    end else begin
      r_state    <= w_state_nx;
      r_bit_cnt  <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_rw       <= w_rw_nx;
      r_ack_half <= w_ack_half_nx;
      r_sda_oe   <= w_oe_nx;
      r_rx_data  <= w_rx_data_nx;
      r_rx_valid <= w_rx_valid_nx;
      r_tx_req   <= w_tx_req_nx;
      r_tx_load  <= r_tx_req;
      r_busy     <= w_busy_nx;
      r_tx_sr    <= w_tx_sr_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_bit_cnt;
    w_shift_nx    = r_shift;
    w_rw_nx       = r_rw;
    w_ack_half_nx = r_ack_half;
    w_oe_nx       = r_sda_oe;
    w_rx_data_nx  = r_rx_data;
    w_rx_valid_nx = 1'b0;
    w_tx_req_nx   = 1'b0;
    w_busy_nx     = r_busy;
    w_tx_sr_nx    = r_tx_load ? tx_data : r_tx_sr;

    if (w_stop) begin
      w_state_nx    = S_IDLE;
      w_cnt_nx      = 3'd0;
      w_ack_half_nx = 1'b0;
      w_oe_nx       = 1'b0;
      w_busy_nx     = 1'b0;
    end else if (w_start) begin
      w_state_nx    = S_ADDR;
      w_cnt_nx      = 3'd0;
      w_ack_half_nx = 1'b0;
      w_oe_nx       = 1'b0;
      w_busy_nx     = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_rw_nx       = w_sda;
              w_ack_half_nx = 1'b0;
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_busy_nx   = 1'b1;
                w_tx_req_nx = w_sda;
                w_state_nx  = S_ADDR_ACK;
              end else begin
                w_state_nx  = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_half) begin
              w_oe_nx       = 1'b1;
              w_ack_half_nx = 1'b1;
            end else begin
              w_ack_half_nx = 1'b0;
              w_cnt_nx      = 3'd0;
              if (r_rw) begin
                w_oe_nx    = ~r_tx_sr[7];
                w_state_nx = S_RD_DATA;
              end else begin
                w_oe_nx    = 1'b0;
                w_state_nx = S_WR_DATA;
              end
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_rx_data_nx  = w_byte;
              w_rx_valid_nx = 1'b1;
              w_ack_half_nx = 1'b0;
              w_state_nx    = S_WR_ACK;
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_half) begin
              w_oe_nx       = 1'b1;
              w_ack_half_nx = 1'b1;
            end else begin
              w_oe_nx       = 1'b0;
              w_ack_half_nx = 1'b0;
              w_cnt_nx      = 3'd0;
              w_state_nx    = S_WR_DATA;
            end
          end
        end
        S_RD_DATA: begin
          // MSB went out on entry; each fall presents the next bit, the
          // eighth fall hands SDA back for the controller's ACK.
          if (w_scl_fall) begin
            w_cnt_nx = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_oe_nx       = 1'b0;
              w_ack_half_nx = 1'b0;
              w_state_nx    = S_RD_ACK;
            end else begin
              w_oe_nx    = ~r_tx_sr[6];
              w_tx_sr_nx = {r_tx_sr[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (!r_ack_half) begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                w_tx_req_nx   = 1'b1;
                w_ack_half_nx = 1'b1;
              end else begin
                w_state_nx = S_WAIT_STOP;
              end
            end
          end else if (w_scl_fall) begin
            w_oe_nx       = ~r_tx_sr[7];
            w_ack_half_nx = 1'b0;
            w_cnt_nx      = 3'd0;
            w_state_nx    = S_RD_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_if.sv
// tb/tb_i2c_slave_if.sv - bench for i2c_slave_if acting as bus controller with a transaction-level model
module tb_i2c_slave_if;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_if #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .busy     (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_txreq = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  logic [7:0] data_q[$];
  logic       prev_oe = 1'b0;
  logic       prev_clr = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target-side handshake responder plus bus-rule monitor.
  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back(rx_data);
    if (tx_req) begin
      n_txreq++;
      tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
    end
    if (rx_valid || tx_req) chk("pulse_exclusive", {31'd0, rx_valid & tx_req}, 32'd0);
    if (sda_oe !== prev_oe && !clr && !prev_clr) chk("oe_change_scl_low", {31'd0, scl_m}, 32'd0);
    prev_oe  = sda_oe;
    prev_clr = clr;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int lo, hi;
    lo = $urandom_range(8, 14);
    hi = $urandom_range(8, 14);
    tick(2); sda_m = b; tick(lo - 2);
    scl_m = 1'b1; tick(hi);
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    int lo, hi;
    lo = $urandom_range(8, 14);
    hi = $urandom_range(8, 14);
    tick(2); sda_m = 1'b1; tick(lo - 2);
    scl_m = 1'b1; tick(hi / 2);
    b = sda_line;
    tick(hi - hi / 2);
    scl_m = 1'b0;
  endtask

  task automatic start_cond();
    tick(4); sda_m = 1'b0; tick(10); scl_m = 1'b0;
  endtask

  task automatic rep_start();
    tick(2); sda_m = 1'b1; tick(10); scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(10); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    tick(2); sda_m = 1'b0; tick(10); scl_m = 1'b1; tick(10);
    sda_m = 1'b1; tick(12);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(bit_v);
    ack = ~bit_v;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      d[i] = bit_v;
    end
    send_bit(~ack);
  endtask

  // One addressed transfer of data_q; expectations follow from the address
  // match and direction alone.
  task automatic txn(input logic [6:0] addr, input logic rw, input string tag);
    logic       ack;
    logic       match;
    logic [7:0] d;
    int         tx0;
    match = (addr == 7'h42);
    tx0   = n_txreq;
    if (match && rw) tx_q = data_q;
    write_byte({addr, rw}, ack);
    chk({tag, "_addr_ack"}, {31'd0, ack}, {31'd0, match});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, match});
    for (int i = 0; i < data_q.size(); i++) begin
      if (!rw) begin
        write_byte(data_q[i], ack);
        chk({tag, "_data_ack"}, {31'd0, ack}, {31'd0, match});
      end else begin
        read_byte(i != data_q.size() - 1, d);
        chk({tag, "_rd_byte"}, {24'd0, d}, {24'd0, match ? data_q[i] : 8'hFF});
      end
    end
    chk({tag, "_rx_count"}, rx_got.size(), (match && !rw) ? data_q.size() : 0);
    for (int i = 0; i < rx_got.size() && i < data_q.size(); i++)
      chk({tag, "_rx_byte"}, {24'd0, rx_got[i]}, {24'd0, data_q[i]});
    chk({tag, "_txreq_count"}, n_txreq - tx0, (match && rw) ? data_q.size() : 0);
    rx_got.delete();
  endtask

  initial begin
    logic       ack;
    logic       bit_v;
    logic       found;
    logic [6:0] addr;
    logic       rw;
    int         nb;

    tick(4);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    clr = 1'b0;
    tick(6);

    data_q = '{8'hA5, 8'h3C};
    start_cond(); txn(7'h42, 1'b0, "wr"); stop_cond();
    chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    data_q = '{8'hFF};
    start_cond(); txn(7'h43, 1'b0, "nomatch"); stop_cond();
    chk("nomatch_busy", {31'd0, busy}, 32'd0);

    data_q = '{8'h96, 8'h0F};
    start_cond(); txn(7'h42, 1'b1, "rd"); stop_cond();
    chk("rd_released", {31'd0, sda_oe}, 32'd0);

    data_q = '{8'h11};
    start_cond(); txn(7'h42, 1'b0, "rs_wr");
    rep_start();
    data_q = '{8'($urandom_range(0, 255))};
    txn(7'h42, 1'b1, "rs_rd"); stop_cond();

    start_cond();
    write_byte({7'h42, 1'b0}, ack);
    chk("part_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    stop_cond();
    chk("part_rx_count", rx_got.size(), 0);
    chk("part_busy", {31'd0, busy}, 32'd0);
    rx_got.delete();
    data_q = '{8'($urandom_range(0, 255))};
    start_cond(); txn(7'h42, 1'b0, "part_next"); stop_cond();

    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'(7'h42 >> (i - 1)));
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (sda_oe === 1'b1) found = 1'b1;
    end
    chk("clr_ack_seen", {31'd0, found}, 32'd1);
    clr = 1'b1;
    tick(1);
    chk("clr_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    clr = 1'b0;
    recv_bit(bit_v);
    chk("clr_ack_gone", {31'd0, bit_v}, 32'd1);
    write_byte(8'($urandom_range(0, 255)), ack);
    chk("clr_data_ignored", {31'd0, ack}, 32'd0);
    chk("clr_rx_count", rx_got.size(), 0);
    stop_cond();
    rx_got.delete();
    data_q = '{8'($urandom_range(0, 255))};
    start_cond(); txn(7'h42, 1'b0, "clr_next"); stop_cond();

    for (int t = 0; t < 8; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127));
      rw   = 1'($urandom_range(0, 1));
      nb   = $urandom_range(1, 3);
      data_q.delete();
      for (int i = 0; i < nb; i++) data_q.push_back(8'($urandom_range(0, 255)));
      start_cond(); txn(addr, rw, "rand"); stop_cond();
      chk("rand_busy_after_stop", {31'd0, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
